regfile_ctx: RTL and testbench

Context save/restore engine for the 3-port register file. It drives the register file's read-address and write ports to stream registers 1..(2^REGBITS−1) out over a valid/ready save channel, or to load them from a valid/ready restore channel. Register 0 is hardwired to zero and is never transferred. The engine sits beside the datapath and stalls the core through `busy` while a transfer is in progress. It serves context switches and debug dump/load.

---
 rtl/regfile_ctx.sv | 97 +++++++++
 tb/tb_regfile_ctx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx.sv
// Context save/restore engine: streams registers 1..2^REGBITS-1 of a 3-port
// register file out on a valid/ready save channel, or loads them from a restore channel.
module regfile_ctx #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               save_req,
  input  logic               restore_req,
  output logic               busy,
  output logic               done,
  output logic [REGBITS-1:0] rf_ra,
  input  logic [WIDTH-1:0]   rf_rd,
  output logic               rf_we,
  output logic [REGBITS-1:0] rf_wa,
  output logic [WIDTH-1:0]   rf_wd,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [1:0]         dbg_state
);

  // Handshakes: a word moves on a rising edge where valid and ready are both
  // high; dout_valid / din_ready are held for the whole SAVE / RESTORE state.
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  localparam logic [REGBITS-1:0] ONE  = REGBITS'(1);
  localparam logic [REGBITS-1:0] LAST = '1;

  state_t             state, state_nx;
  logic [REGBITS-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= ONE;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    rf_ra      = '0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;
    dout       = '0;
    dout_valid = 1'b0;
    din_ready  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = ONE;
        if (save_req)         state_nx = SAVE;
        else if (restore_req) state_nx = RESTORE;
      end
      SAVE: begin
        busy       = 1'b1;
        rf_ra      = cnt;
        dout       = rf_rd;
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (cnt == LAST) state_nx = DONE;
          else             cnt_nx   = cnt + ONE;
        end
      end
      RESTORE: begin
        busy      = 1'b1;
        din_ready = 1'b1;
        rf_we     = din_valid;
        rf_wa     = cnt;
        rf_wd     = din;
        if (din_valid) begin
          if (cnt == LAST) state_nx = DONE;
          else             cnt_nx   = cnt + ONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        cnt_nx   = ONE;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_regfile_ctx.sv
// Bench for regfile_ctx: behavioural register file plus a reference image of
// its contents; expected stream words and writes go through a scoreboard queue.
module tb_regfile_ctx;
  localparam int W  = 16;
  localparam int RB = 4;
  localparam int N  = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          save_req, restore_req;
  logic          busy, done;
  logic [RB-1:0] rf_ra, rf_wa;
  logic [W-1:0]  rf_rd, rf_wd, dout, din;
  logic          rf_we, dout_valid, dout_ready, din_valid, din_ready;
  logic [1:0]    dbg_state;

  regfile_ctx #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk(clk), .reset_n(reset_n), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file seen by the DUT; reg 0 reads as zero
  logic [W-1:0] rf [0:N];
  logic [W-1:0] ref_rf [0:N];
  assign rf_rd = (rf_ra == '0) ? '0 : rf[rf_ra];
  always @(posedge clk) if (rf_we && rf_wa != '0) rf[rf_wa] <= rf_wd;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int we_cnt = 0;
  logic [1+RB+W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, busy, done, rf_we, rf_ra, rf_wa, rf_wd, dout, dout_valid, din_ready};
  endfunction

  // scoreboard monitor: every accepted save word and every write is popped here
  always @(negedge clk) begin
    if (reset_n) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL save_word: got %0h with no expected entry", dout);
        end else check("save_word", {1'b0, rf_ra, dout}, exp_q.pop_front());
      end
      if (rf_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL rf_write: got addr %0h data %0h with no expected entry", rf_wa, rf_wd);
        end else check("rf_write", {1'b1, rf_wa, rf_wd}, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  // driver: save with optional stall window, random ready and simultaneous requests
  task automatic do_save(input bit both, input int stall_at, input int stall_len, input bit rnd);
    int cycles, stalls, acc, dr_cnt, st;
    for (int i = 1; i <= N; i++) exp_q.push_back({1'b0, RB'(i), ref_rf[i]});
    @(posedge clk); #1;
    save_req = 1'b1; restore_req = both;
    @(posedge clk); #1;
    save_req = 1'b0; restore_req = 1'b0;
    cycles = 1; stalls = 0; acc = 0; dr_cnt = 0; st = 0;
    while (!done && cycles < 500) begin
      if (acc == stall_at - 1 && st < stall_len) begin
        dout_ready = 1'b0; st++;
      end else if (rnd) dout_ready = ($urandom_range(0, 3) != 0);
      else dout_ready = 1'b1;
      if (!dout_ready) stalls++;
      if (din_ready) dr_cnt++;
      restore_req = both && (cycles == 3);
      @(posedge clk);
      if (dout_valid && dout_ready) acc++;
      #1; cycles++;
    end
    restore_req = 1'b0; dout_ready = 1'b0;
    exp_done++;
    check("save_latency", cycles, N + 1 + stalls);
    check("save_din_ready", dr_cnt, 0);
    check("save_words", acc, N);
    @(posedge clk); #1;
    check("save_done_one_cycle", {busy, done}, 0);
    @(posedge clk); #1;
    check("save_no_queued_req", busy, 0);
  endtask

  // driver: restore with random din_valid gaps; abort_after > 0 resets after that many words
  task automatic do_restore(input int abort_after, input bit rnd_data);
    logic [W-1:0] d [1:N];
    int cycles, gaps, idx, w0;
    for (int i = 1; i <= N; i++) d[i] = rnd_data ? W'($urandom) : W'(16'hA000 + i);
    w0 = we_cnt;
    @(posedge clk); #1;
    restore_req = 1'b1;
    @(posedge clk); #1;
    restore_req = 1'b0;
    cycles = 1; gaps = 0; idx = 1;
    while (!done && cycles < 500) begin
      if (abort_after != 0 && idx > abort_after) begin
        din_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_outs_zero", all_outs(), 0);
        check("abort_state_idle", dbg_state, 0);
        check("abort_queue_drained", exp_q.size(), 0);
        check("abort_writes", we_cnt - w0, abort_after);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      din_valid = ($urandom_range(0, 2) != 0);
      if (din_valid) begin
        din = d[idx];
        exp_q.push_back({1'b1, RB'(idx), d[idx]});
        ref_rf[idx] = d[idx];
      end else gaps++;
      @(posedge clk);
      if (din_valid && din_ready) idx++;
      #1; cycles++;
    end
    din_valid = 1'b0;
    exp_done++;
    check("restore_latency", cycles, N + 1 + gaps);
    check("restore_writes", we_cnt - w0, N);
    @(posedge clk); #1;
    check("restore_done_one_cycle", {busy, done}, 0);
  endtask

  task automatic check_rf(input string name);
    for (int i = 0; i <= N; i++) check(name, {RB'(i), rf[i]}, {RB'(i), ref_rf[i]});
  endtask

  initial begin
    reset_n = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    dout_ready = 1'b0; din = '0; din_valid = 1'b0;
    for (int i = 0; i <= N; i++) begin
      rf[i] = (i == 0) ? '0 : W'(16'h1000 + i);
      ref_rf[i] = rf[i];
    end
    #12;
    check("reset_outs_zero", all_outs(), 0);
    check("reset_state_idle", dbg_state, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_outs_zero", all_outs(), 0);

    do_save(1'b0, 0, 0, 1'b0);
    do_save(1'b0, 5, 3, 1'b0);
    do_restore(0, 1'b0);
    check_rf("readback_after_restore");
    do_save(1'b1, 0, 0, 1'b1);
    do_restore(6, 1'b1);
    check_rf("readback_after_abort");
    do_save(1'b0, 0, 0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      do_restore(0, 1'b1);
      do_save(1'b0, 0, 0, 1'b1);
    end
    check_rf("readback_final");

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("done_pulses", done_cnt, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

endmodule
